// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and the memory stage,
// one access outstanding, memory stage first, with an optional BUSY timeout.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        ram_en,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready,
   output logic        bus_err
);
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   logic if_ack_q, if_ack_d, mem_ack_q, mem_ack_d, bus_err_q, bus_err_d;
   logic [31:0] ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d, rdata;
   logic tmo, done;
   assign tmo   = (TIMEOUT != 0) && !ram_ready && (cnt_q == CW'(TIMEOUT - 1));
   assign done  = ram_ready | tmo;
   assign rdata = ram_ready ? ram_rdata : '0;
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ram_en_d    = ram_en_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      bus_err_d   = bus_err_q;
      if (state_q == IDLE) begin
         // a side being acked this cycle sits out, which makes held requests alternate
         if (mem_req && !mem_ack_q) begin
            state_d     = BUSY_MEM;
            cnt_d       = '0;
            ram_en_d    = 1'b1;
            ram_we_d    = mem_we;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
         end else if (if_req && !if_ack_q) begin
            state_d    = BUSY_IF;
            cnt_d      = '0;
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b0;
            ram_addr_d = if_addr;
         end
      end else if (done) begin
         state_d    = IDLE;
         ram_en_d   = 1'b0;
         ram_we_d   = 1'b0;
         if_ack_d   = state_q == BUSY_IF;
         mem_ack_d  = state_q == BUSY_MEM;
         if_rdata_d = (state_q == BUSY_IF) ? rdata : if_rdata_q;
         mem_rdata_d = (state_q == BUSY_MEM && !ram_we_q) ? rdata : mem_rdata_q;
         bus_err_d  = bus_err_q | tmo;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         bus_err_q   <= bus_err_d;
      end
   end
   assign if_ack    = if_ack_q;
   assign mem_ack   = mem_ack_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign bus_err   = bus_err_q;
   assign stall_if  = rst & if_req & ~if_ack_q;
   assign stall_mem = rst & mem_req & ~mem_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors; expected grants and acks are queued by the
// stimulus and checked by a separate negedge monitor that also drives the RAM model.
module tb_mem_port_arbiter;
   logic clk = 1'b0, rst = 1'b0;
   logic if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, ram_ready = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
   logic if_ack, mem_ack, stall_if, stall_mem, ram_en, ram_we, bus_err;
   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
   mem_port_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_ready(ram_ready), .bus_err(bus_err)
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} grant_t;
   typedef struct {logic is_mem; logic [31:0] data; logic err; int busy;} ack_t;
   grant_t gq[$];
   ack_t   aq[$];
   int vectors = 0, miscompares = 0;
   int cyc = 0, g_cyc = 0, bc = 0, lat = 1;
   logic idle_noise = 1'b0, prev_en = 1'b0;
   logic [31:0] hold_addr = '0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic logic [31:0] ram_model(input logic [31:0] a);
      case (a)
         32'h10:  return 32'h20010005;
         32'h141: return 32'h11223344;
         32'h200: return 32'hDEADBEEF;
         default: return ~a;
      endcase
   endfunction
   always @(posedge clk) cyc++;
   // RAM responder (ready in the lat-th BUSY cycle) followed by the scoreboard monitor
   always @(negedge clk) begin
      grant_t g;
      ack_t a;
      if (ram_en) begin
         bc++;
         ram_ready = (bc >= lat);
      end else begin
         bc = 0;
         ram_ready = idle_noise ? ~ram_ready : 1'b0;
      end
      ram_rdata = ram_model(ram_addr);
      if (!rst) prev_en = 1'b0;
      else begin
         if (ram_en && !prev_en) begin
            g_cyc = cyc;
            hold_addr = ram_addr;
            if (gq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL grant: unexpected access to %h, none required", ram_addr);
            end else begin
               g = gq.pop_front();
               chk("grant_addr", ram_addr, g.addr);
               chk("grant_we", {31'b0, ram_we}, {31'b0, g.we});
               if (g.we) chk("grant_wdata", ram_wdata, g.wdata);
            end
         end else if (ram_en) chk("busy_addr_hold", ram_addr, hold_addr);
         if (if_ack || mem_ack) begin
            if (aq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL ack: unexpected ack if=%b mem=%b, none required", if_ack, mem_ack);
            end else begin
               a = aq.pop_front();
               chk("ack_side_mem", {30'b0, if_ack, mem_ack}, {30'b0, ~a.is_mem, a.is_mem});
               chk("ack_rdata", a.is_mem ? mem_rdata : if_rdata, a.data);
               chk("ack_bus_err", {31'b0, bus_err}, {31'b0, a.err});
               chk("ack_busy_cycles", cyc - g_cyc, a.busy);
            end
         end
         prev_en = ram_en;
      end
   end
   task automatic serve(input int n_mem, input int n_if);
      int gm = 0, gi = 0;
      for (int c = 0; c < 200 && (mem_req || if_req); c++) begin
         @(negedge clk);
         chk("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~if_ack});
         chk("stall_mem", {31'b0, stall_mem}, {31'b0, mem_req & ~mem_ack});
         if (mem_ack) begin gm++; if (gm >= n_mem) mem_req = 1'b0; end
         if (if_ack) begin gi++; if (gi >= n_if) if_req = 1'b0; end
      end
      if (mem_req || if_req) begin
         vectors++; miscompares++;
         $display("FAIL serve_bound: requests still pending mem=%b if=%b, required done", mem_req, if_req);
         mem_req = 1'b0; if_req = 1'b0;
      end
   endtask
   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_ack"}, {31'b0, if_ack}, 0);
      chk({tag, "_mem_ack"}, {31'b0, mem_ack}, 0);
      chk({tag, "_stall_if"}, {31'b0, stall_if}, 0);
      chk({tag, "_stall_mem"}, {31'b0, stall_mem}, 0);
      chk({tag, "_ram_en"}, {31'b0, ram_en}, 0);
      chk({tag, "_ram_we"}, {31'b0, ram_we}, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_wdata"}, ram_wdata, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_mem_rdata"}, mem_rdata, 0);
      chk({tag, "_bus_err"}, {31'b0, bus_err}, 0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);
      // fetch alone, ready in the 4th BUSY cycle
      lat = 4;
      gq.push_back('{32'h10, 1'b0, 32'h0});
      aq.push_back('{1'b0, 32'h20010005, 1'b0, 4});
      if_addr = 32'h10; if_req = 1'b1;
      serve(0, 1);
      chk("fetch_if_rdata", if_rdata, 32'h20010005);
      repeat (3) @(negedge clk);
      // simultaneous load and fetch: memory stage first
      lat = 2;
      gq.push_back('{32'h141, 1'b0, 32'h0});
      gq.push_back('{32'h10, 1'b0, 32'h0});
      aq.push_back('{1'b1, 32'h11223344, 1'b0, 2});
      aq.push_back('{1'b0, 32'h20010005, 1'b0, 2});
      mem_we = 1'b0; mem_addr = 32'h141; mem_req = 1'b1; if_req = 1'b1;
      serve(1, 1);
      repeat (2) @(negedge clk);
      // load 0xDEADBEEF, then a store that must leave mem_rdata alone
      lat = 1;
      gq.push_back('{32'h200, 1'b0, 32'h0});
      aq.push_back('{1'b1, 32'hDEADBEEF, 1'b0, 1});
      mem_addr = 32'h200; mem_req = 1'b1;
      serve(1, 0);
      lat = 3;
      gq.push_back('{32'h141, 1'b1, 32'h7B});
      aq.push_back('{1'b1, 32'hDEADBEEF, 1'b0, 3});
      mem_we = 1'b1; mem_addr = 32'h141; mem_wdata = 32'h7B; mem_req = 1'b1;
      serve(1, 0);
      mem_we = 1'b0;
      repeat (2) @(negedge clk);
      chk("store_keeps_mem_rdata", mem_rdata, 32'hDEADBEEF);
      // timeout after 8 silent BUSY cycles, then a normal fetch
      lat = 255;
      gq.push_back('{32'h300, 1'b0, 32'h0});
      aq.push_back('{1'b1, 32'h0, 1'b1, 8});
      mem_addr = 32'h300; mem_req = 1'b1;
      serve(1, 0);
      repeat (3) @(negedge clk);
      chk("bus_err_sticky", {31'b0, bus_err}, 1);
      lat = 1;
      gq.push_back('{32'h10, 1'b0, 32'h0});
      aq.push_back('{1'b0, 32'h20010005, 1'b1, 1});
      if_req = 1'b1;
      serve(0, 1);
      repeat (2) @(negedge clk);
      // reset in the middle of a BUSY_MEM access
      lat = 255;
      gq.push_back('{32'h141, 1'b0, 32'h0});
      mem_addr = 32'h141; mem_req = 1'b1;
      repeat (4) @(negedge clk);
      chk("busy_before_reset", {31'b0, ram_en}, 1);
      rst = 1'b0;
      #1;
      chk_all_zero("midreset");
      mem_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      lat = 2;
      gq.push_back('{32'h141, 1'b0, 32'h0});
      aq.push_back('{1'b1, 32'h11223344, 1'b0, 2});
      mem_req = 1'b1;
      serve(1, 0);
      repeat (2) @(negedge clk);
      // back-to-back with ram_ready toggling while IDLE
      lat = 1; idle_noise = 1'b1;
      for (int i = 0; i < 2; i++) begin
         gq.push_back('{32'h200, 1'b0, 32'h0});
         gq.push_back('{32'h10, 1'b0, 32'h0});
         aq.push_back('{1'b1, 32'hDEADBEEF, 1'b0, 1});
         aq.push_back('{1'b0, 32'h20010005, 1'b0, 1});
      end
      mem_addr = 32'h200; mem_req = 1'b1; if_req = 1'b1;
      serve(2, 2);
      repeat (6) @(negedge clk);
      idle_noise = 1'b0;
      repeat (2) @(negedge clk);
      chk("grant_queue_drained", gq.size(), 0);
      chk("ack_queue_drained", aq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- TIMEOUT, 16, maximum BUSY cycles without ram_ready before abort; 0 disables the timeout.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch requests a read.
- if_addr  in  32  fetch address.
- if_ack  out  1  one-cycle pulse; fetch transaction finished.
- if_rdata  out  32  registered fetch read data.
- mem_req  in  1  load/store stage request.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address, taken from the ALU output.
- mem_wdata  in  32  store data, taken from operand B.
- mem_ack  out  1  one-cycle pulse; data transaction finished.
- mem_rdata  out  32  registered load data.
- stall_if  out  1  fetch stage must hold.
- stall_mem  out  1  memory stage must hold.
- ram_en  out  1  unified single-port RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.
- ram_ready  in  1  RAM completes the current access.
- bus_err  out  1  sticky flag; a timeout occurred.

Function
REQ-003 The block shall share one single-port RAM between fetch and the memory stage, with at most one access outstanding at a time.
REQ-004 The FSM shall have exactly three states: IDLE, BUSY_IF, BUSY_MEM.
REQ-005 In IDLE, the arbiter shall sample the requests at each edge and grant as follows:
- mem_req has priority over if_req (older instruction first).
- A requester whose ack is high in the current cycle shall be ignored for arbitration in that cycle.
- With no eligible request, the FSM stays in IDLE.
REQ-006 On a grant edge, the block shall do all of the following:
- Register ram_addr, ram_we and ram_wdata from the winner's inputs. Fetch is always a read; ram_wdata is don't-care for reads.
- Set ram_en=1.
- Enter BUSY_IF or BUSY_MEM.
REQ-007 In BUSY_*, ram_en, ram_we, ram_addr and ram_wdata shall stay constant until the transaction ends.
REQ-008 A BUSY_* state shall end at the first edge where ram_ready=1. At that edge the block shall:
- Return to IDLE.
- Clear ram_en and ram_we.
- Capture ram_rdata into if_rdata (BUSY_IF) or mem_rdata (BUSY_MEM load only).
- Assert the matching ack for exactly the next cycle.
REQ-009 For stores, mem_rdata shall keep its previous value.
REQ-010 Minimum latency shall be: request sampled at edge N, grant; ram_ready high during cycle N+1; ack high during cycle N+2.
REQ-011 ram_ready asserted while in IDLE shall be ignored.
REQ-012 The timeout counter shall clear on grant and increment on each BUSY edge with ram_ready=0.
REQ-013 When TIMEOUT≠0 and the counter reaches TIMEOUT, the block shall:
- Return to IDLE.
- Pulse the matching ack with the read data register set to 0.
- Set bus_err=1; bus_err stays set until reset.
REQ-014 stall_if shall equal if_req & ~if_ack, and stall_mem shall equal mem_req & ~mem_ack (combinational).
REQ-015 A request dropped before it is granted shall be withdrawn with no access.
REQ-016 A request dropped after grant shall still complete; its ack pulse is still produced.
REQ-017 Requests held continuously by both sides shall alternate MEM, IF, MEM, IF... as a consequence of REQ-005.

Reset
REQ-018 While rst=0, the block shall asynchronously force:
- state=IDLE and counter=0.
- All outputs 0: acks, stalls, ram_en, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, bus_err.
REQ-019 Reset during BUSY_* shall abort the access, and no ack shall follow reset release.

Verification
REQ-020 Fetch alone: if_req=1, if_addr=0x00000010, ram_ready after 3 BUSY cycles with ram_rdata=0x20010005 -> ram_addr=0x10, ram_we=0; single if_ack pulse; if_rdata=0x20010005; stall_if=1 until the ack cycle.
REQ-021 Simultaneous requests: if_req with if_addr=0x10, plus a load (mem_we=0, mem_addr=0x00000141), both at the same edge -> ram_addr sequence 0x141 then 0x10; mem_ack precedes if_ack; stall_if stays high throughout.
REQ-022 Store: mem_we=1, mem_addr=0x141, mem_wdata=0x0000007B, with mem_rdata previously 0xDEADBEEF -> ram_we=1, ram_wdata=0x7B; mem_ack pulse; mem_rdata remains 0xDEADBEEF.
REQ-023 Timeout: TIMEOUT=8, ram_ready held 0 -> after 8 BUSY cycles an ack pulse occurs, read data=0, bus_err=1 and stays 1; the next request is served normally.
REQ-024 Reset mid-access: rst=0 during BUSY_MEM -> ram_en=0 and all outputs 0 immediately; no mem_ack after release; a fresh request is granted from IDLE.
REQ-025 Back-to-back: both requests held for 4 transactions with ram_ready=1 each BUSY cycle -> grant order MEM, IF, MEM, IF; ram_ready pulses while IDLE have no effect.
